// File: rtl/dsp_pkg.sv
// -----------------------------------------------------------------------------
// dsp_pkg -- shared constants for the phase generator slice.
//   DEG_180 / DEG_360      : half and full turn in degrees
//   DEG_MIN / DEG_MAX      : legal phase range, -180..179
//   ST_IDLE/ST_RUN/ST_DONE : phase_gen FSM state encoding
// -----------------------------------------------------------------------------
package dsp_pkg;

    localparam int DEG_180 = 32'sd180;
    localparam int DEG_360 = 32'sd360;
    localparam int DEG_MIN = -32'sd180;
    localparam int DEG_MAX = 32'sd179;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/deg_wrap.sv
// -----------------------------------------------------------------------------
// deg_wrap -- combinational angle adder with a single +/-360 correction.
// Ports:
//   a, b : W+1-bit signed operands (degrees)
//   y    : W+1-bit signed wrapped sum
// The sum is formed one bit wider so that an out-of-range intermediate is
// seen before truncation; only one correction step is applied.
// -----------------------------------------------------------------------------
module deg_wrap
    import dsp_pkg::*;
#(
    parameter int W = 8
) (
    input  logic signed [W:0] a,
    input  logic signed [W:0] b,
    output logic signed [W:0] y
);

    localparam logic signed [W+1:0] MAX_S = (W+2)'(DEG_MAX);
    localparam logic signed [W+1:0] MIN_S = (W+2)'(DEG_MIN);
    localparam logic signed [W+1:0] TURN_S = (W+2)'(DEG_360);

    logic signed [W+1:0] sum_s;
    logic signed [W+1:0] fix_s;

    // Widened sum followed by a single range correction.
    always_comb begin
        sum_s = $signed({a[W], a}) + $signed({b[W], b});
        if (sum_s > MAX_S) begin
            fix_s = sum_s - TURN_S;
        end else if (sum_s < MIN_S) begin
            fix_s = sum_s + TURN_S;
        end else begin
            fix_s = sum_s;
        end
        y = fix_s[W:0];
    end

endmodule

// File: rtl/phase_gen.sv
// -----------------------------------------------------------------------------
// phase_gen -- burst generator of (amplitude, phase) samples for a CORDIC
// modulator. A burst starts with phi0 and advances by step on every accepted
// sample (valid & ready); a nonzero len ends the burst with a one-cycle done.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   start, stop       : burst request (IDLE only) / abort
//   r_set, phi0_in,
//   step_in, len_in   : burst parameters, latched on an accepted start
//   chirp_in          : step increment per sample (PHASE_GEN_SWEEP_EN only)
//   ready             : downstream accepts the current sample
//   r_out, phi_out    : registered amplitude and phase (-180..179)
//   valid, busy, done : sample present / FSM active / normal end pulse
// Build option: define PHASE_GEN_SWEEP_EN to add the chirp_in port and a
// linearly sweeping step.
// -----------------------------------------------------------------------------
module phase_gen
    import dsp_pkg::*;
#(
    parameter int W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic signed [W:0] r_set,
    input  logic signed [W:0] phi0_in,
    input  logic signed [W:0] step_in,
`ifdef PHASE_GEN_SWEEP_EN
    input  logic signed [W:0] chirp_in,
`endif
    input  logic [15:0]       len_in,
    input  logic              ready,
    output logic signed [W:0] r_out,
    output logic signed [W:0] phi_out,
    output logic              valid,
    output logic              busy,
    output logic              done
);

    localparam logic signed [W:0] MAX_W = (W+1)'(DEG_MAX);
    localparam logic signed [W:0] MIN_W = (W+1)'(DEG_MIN);

    // Saturate an angle into the legal phase range.
    function automatic logic signed [W:0] clamp_deg(input logic signed [W:0] x);
        logic signed [W:0] y;
        if (x > MAX_W) begin
            y = MAX_W;
        end else if (x < MIN_W) begin
            y = MIN_W;
        end else begin
            y = x;
        end
        return y;
    endfunction

    logic [1:0]        state_r;
    logic [15:0]       cnt_r;
    logic [15:0]       len_r;
    logic signed [W:0] step_r;
    logic signed [W:0] phi_nx_s;
    logic              accept_s;
    logic              last_s;

    assign accept_s = valid & ready;
    // len_r == 0 means continuous; the counter then wraps freely.
    assign last_s   = (len_r != 16'd0) && (cnt_r == (len_r - 16'd1));

    deg_wrap #(.W(W)) u_phase_wrap (
        .a (phi_out),
        .b (step_r),
        .y (phi_nx_s)
    );

`ifdef PHASE_GEN_SWEEP_EN
    logic signed [W:0] chirp_r;
    logic signed [W:0] step_nx_s;

    deg_wrap #(.W(W)) u_step_wrap (
        .a (step_r),
        .b (chirp_r),
        .y (step_nx_s)
    );
`endif

    // Burst FSM and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 16'd0;
            len_r   <= 16'd0;
            step_r  <= '0;
            r_out   <= '0;
            phi_out <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef PHASE_GEN_SWEEP_EN
            chirp_r <= '0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start && !stop) begin
                        r_out   <= r_set;
                        phi_out <= clamp_deg(phi0_in);
                        step_r  <= clamp_deg(step_in);
                        len_r   <= len_in;
                        cnt_r   <= 16'd0;
`ifdef PHASE_GEN_SWEEP_EN
                        chirp_r <= chirp_in;
`endif
                        valid   <= 1'b1;
                        busy    <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        valid   <= 1'b0;
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // Abort wins over a same-cycle completion.
                    if (stop) begin
                        valid   <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                        state_r <= ST_IDLE;
                    end else if (accept_s) begin
                        phi_out <= phi_nx_s;
                        cnt_r   <= cnt_r + 16'd1;
`ifdef PHASE_GEN_SWEEP_EN
                        step_r  <= step_nx_s;
`endif
                        if (last_s) begin
                            valid   <= 1'b0;
                            done    <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    valid   <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    valid   <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phase_gen.sv
module tb_phase_gen;

    localparam int W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              stop;
    logic              ready;
    logic signed [W:0] r_set;
    logic signed [W:0] phi0_in;
    logic signed [W:0] step_in;
    logic [15:0]       len_in;
    logic signed [W:0] r_out;
    logic signed [W:0] phi_out;
    logic              valid;
    logic              busy;
    logic              done;
`ifdef PHASE_GEN_SWEEP_EN
    logic signed [W:0] chirp_in;
`endif

    int n_vec = 0;
    int n_err = 0;

    phase_gen #(.W(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .r_set    (r_set),
        .phi0_in  (phi0_in),
        .step_in  (step_in),
`ifdef PHASE_GEN_SWEEP_EN
        .chirp_in (chirp_in),
`endif
        .len_in   (len_in),
        .ready    (ready),
        .r_out    (r_out),
        .phi_out  (phi_out),
        .valid    (valid),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int r, input int p0, input int st, input int len);
        r_set   = (W+1)'(r);
        phi0_in = (W+1)'(p0);
        step_in = (W+1)'(st);
        len_in  = 16'(len);
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // Checks a full burst: each sample in turn, then the done pulse and idle.
    task automatic expect_burst(input string tag, input int r, input int exp[$]);
        for (int i = 0; i < exp.size(); i++) begin
            chk($sformatf("%s.phi[%0d]", tag, i), int'(phi_out), exp[i]);
            chk($sformatf("%s.valid[%0d]", tag, i), int'(valid), 1);
            chk($sformatf("%s.r[%0d]", tag, i), int'(r_out), r);
            tick();
        end
        chk({tag, ".done"}, int'(done), 1);
        chk({tag, ".done_valid"}, int'(valid), 0);
        chk({tag, ".done_busy"}, int'(busy), 1);
        tick();
        chk({tag, ".after_done"}, int'(done), 0);
        chk({tag, ".after_busy"}, int'(busy), 0);
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        ready   = 1'b1;
        r_set   = '0;
        phi0_in = '0;
        step_in = '0;
        len_in  = 16'd0;
`ifdef PHASE_GEN_SWEEP_EN
        chirp_in = '0;
`endif
        tick();
        tick();
        reset = 1'b0;
        chk("rst.valid", int'(valid), 0);
        chk("rst.busy", int'(busy), 0);
        chk("rst.done", int'(done), 0);
        chk("rst.phi", int'(phi_out), 0);
        chk("rst.r", int'(r_out), 0);

        // Basic burst.
        launch(100, 0, 30, 4);
        expect_burst("b30", 100, '{0, 30, 60, 90});

        // Wrap in both directions.
        launch(50, 170, 20, 3);
        expect_burst("wrap_up", 50, '{170, -170, -150});
        launch(-7, -170, -20, 3);
        expect_burst("wrap_dn", -7, '{-170, 170, 150});

        // Back-pressure after sample 1; start asserted mid-burst is ignored.
        launch(10, 0, 30, 4);
        chk("bp.s0", int'(phi_out), 0);
        tick();
        chk("bp.s1", int'(phi_out), 30);
        ready   = 1'b0;
        start   = 1'b1;
        phi0_in = (W+1)'(-90);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("bp.hold[%0d]", i), int'(phi_out), 30);
            chk($sformatf("bp.hold_v[%0d]", i), int'(valid), 1);
        end
        ready = 1'b1;
        start = 1'b0;
        tick();
        chk("bp.s2", int'(phi_out), 60);
        tick();
        chk("bp.s3", int'(phi_out), 90);
        chk("bp.s3_v", int'(valid), 1);
        tick();
        chk("bp.done", int'(done), 1);
        chk("bp.done_v", int'(valid), 0);
        tick();

        // Continuous burst, then abort after ten samples.
        launch(20, 0, 10, 0);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("cont.phi[%0d]", i), int'(phi_out), i * 10);
            tick();
        end
        chk("cont.still_run", int'(valid), 1);
        stop = 1'b1;
        tick();
        chk("stop.valid", int'(valid), 0);
        chk("stop.done", int'(done), 0);
        chk("stop.busy", int'(busy), 0);
        tick();
        chk("stop.done2", int'(done), 0);
        start = 1'b1;
        tick();
        chk("startstop.busy", int'(busy), 0);
        chk("startstop.valid", int'(valid), 0);
        start = 1'b0;
        stop  = 1'b0;

        // Clamping of phi0 and step.
        launch(5, 0, -250, 2);
        expect_burst("clamp_step", 5, '{0, -180});
        launch(33, 200, 0, 5);
        chk("clamp.phi0", int'(phi_out), 179);
        tick();
        chk("clamp.busy", int'(busy), 1);

        // Reset mid-burst.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst.valid", int'(valid), 0);
        chk("midrst.busy", int'(busy), 0);
        chk("midrst.done", int'(done), 0);
        chk("midrst.phi", int'(phi_out), 0);
        chk("midrst.r", int'(r_out), 0);
        tick();
        chk("midrst.done2", int'(done), 0);

`ifdef PHASE_GEN_SWEEP_EN
        chirp_in = (W+1)'(5);
        launch(1, 0, 10, 4);
        chirp_in = '0;
        expect_burst("sweep", 1, '{0, 10, 25, 45});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
